// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Op encoding matches the two-bit op field driven by the decode stage.
package mdu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the multiply/divide datapath, on unsigned magnitudes.
// {acc_hi, acc_lo} is the working pair: partial product + multiplier, or remainder + dividend/quotient.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: add the multiplicand when the multiplier LSB is set, then shift the pair right.
  // Divide: shift the next dividend bit into the remainder, keep the trial difference only
  // when it did not borrow; the borrow bit is the extra top bit of the WIDTH+1 subtraction.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    next_hi = '0;
    next_lo = '0;
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        next_hi = diff[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = shifted[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Operands are reduced to magnitudes on acceptance; signs are re-applied in FINISH.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state;
  logic [CNT_W-1:0]   count;
  logic               mode_div;
  logic               neg_result;
  logic               neg_rem;
  logic               dz_pending;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   rs_reg;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;

  op_e                op_sel;
  logic               start_signed;
  logic               start_div;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quo_fin;
  logic [WIDTH-1:0]   rem_fin;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (mode_div),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .operand  (operand),
    .next_hi  (step_hi),
    .next_lo  (step_lo)
  );

  // Magnitude extraction at acceptance; the most negative value maps onto its own bit pattern,
  // which is already the correct unsigned magnitude.
  always_comb begin
    op_sel       = op_e'(op);
    start_signed = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    start_div    = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
    rs_neg       = start_signed && rs_val[WIDTH-1];
    rt_neg       = start_signed && rt_val[WIDTH-1];
    rs_mag       = rs_neg ? -rs_val : rs_val;
    rt_mag       = rt_neg ? -rt_val : rt_val;
  end

  // Sign post-processing of the finished magnitudes.
  always_comb begin
    prod_fin = neg_result ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fin  = neg_result ? -acc_lo : acc_lo;
    rem_fin  = neg_rem ? -acc_hi : acc_hi;
  end

  // Control FSM plus all architectural and working registers; done is a registered one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      mode_div    <= 1'b0;
      neg_result  <= 1'b0;
      neg_rem     <= 1'b0;
      dz_pending  <= 1'b0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      operand     <= '0;
      rs_reg      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_div    <= start_div;
            neg_result  <= rs_neg ^ rt_neg;
            neg_rem     <= start_div && rs_neg;
            dz_pending  <= start_div && (rt_val == '0);
            rs_reg      <= rs_val;
            acc_hi      <= '0;
            acc_lo      <= start_div ? rs_mag : rt_mag;
            operand     <= start_div ? rt_mag : rs_mag;
            count       <= CNT_W'(WIDTH - 1);
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= S_CALC;
          end else begin
            if (mthi) hi <= rs_val;
            if (mtlo) lo <= rs_val;
          end
        end
        S_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (count == '0) begin
            state <= S_FINISH;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        S_FINISH: begin
          if (!mode_div) begin
            hi <= prod_fin[2*WIDTH-1:WIDTH];
            lo <= prod_fin[WIDTH-1:0];
          end else if (dz_pending) begin
            hi <= rs_reg;
            lo <= '1;
          end else begin
            hi <= rem_fin;
            lo <= quo_fin;
          end
          div_by_zero <= dz_pending;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
